tpu_host_driver: RTL

//   Host-side transmitter for the TPU pin interface. Takes framed byte commands on a ready/valid

---
 rtl/tpu_drv_pkg.sv | 24 ++
 rtl/tpu_host_driver_if.sv | 31 +++
 rtl/drv_result_buf.sv | 68 ++++++
 rtl/tpu_host_driver.sv | 112 +++++++++++
 4 files changed

// File: rtl/tpu_drv_pkg.sv
// Shared opcodes, FSM state type and frame helpers for the TPU host driver.
// Pure definitions, no logic; imported by every tpu_host_driver file.
package tpu_drv_pkg;

  localparam logic [7:0] OP_W   = 8'h01;
  localparam logic [7:0] OP_INP = 8'h02;
  localparam logic [7:0] OP_INS = 8'h03;
  localparam logic [7:0] OP_RUN = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } drv_state_t;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == OP_W) || (op == OP_INP) || (op == OP_INS);
  endfunction

endpackage

// File: rtl/tpu_host_driver_if.sv
// Command stream, TPU pin bundle and result stream of the TPU host driver.
// master = driver side, slave = host/TPU side.
interface tpu_host_driver_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] ui_in;
  logic       fetch_w;
  logic       fetch_inp;
  logic       fetch_ins;
  logic       start;
  logic [7:0] tpu_out;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic       err;

  modport master (
    input  s_valid, s_data, tpu_out, m_ready,
    output s_ready, ui_in, fetch_w, fetch_inp, fetch_ins, start,
           m_valid, m_data, m_last, busy, err
  );

  modport slave (
    output s_valid, s_data, tpu_out, m_ready,
    input  s_ready, ui_in, fetch_w, fetch_inp, fetch_ins, start,
           m_valid, m_data, m_last, busy, err
  );
endinterface

// File: rtl/drv_result_buf.sv
// Result register file: one byte/cycle write during capture, read pointer advanced per drain handshake.
// Latency: read data is combinational on rd pointer; no backpressure on writes. Option macro: TPU_DRV_OUTSUM_EN.
module drv_result_buf #(
  parameter int OUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_done,
  input  logic       rd_adv,
  output logic [7:0] rd_data,
  output logic       rd_last
);

`ifdef TPU_DRV_OUTSUM_EN
  localparam int N_RD = OUT_BYTES + 1;
`else
  localparam int N_RD = OUT_BYTES;
`endif
  localparam int PW = $clog2(OUT_BYTES + 2);
  localparam int AW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    mem [OUT_BYTES];
`ifdef TPU_DRV_OUTSUM_EN
  logic [7:0]    xsum;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < OUT_BYTES; i++) mem[i] <= 8'h00;
`ifdef TPU_DRV_OUTSUM_EN
      xsum   <= 8'h00;
`endif
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
`ifdef TPU_DRV_OUTSUM_EN
      xsum   <= 8'h00;
`endif
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
`ifdef TPU_DRV_OUTSUM_EN
        xsum                <= xsum ^ wr_data;
`endif
      end
      if (rd_adv && !rd_last) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign wr_done = (wr_ptr == PW'(OUT_BYTES - 1));
  assign rd_last = (rd_ptr == PW'(N_RD - 1));

`ifdef TPU_DRV_OUTSUM_EN
  // Checksum slot sits one past the captured bytes.
  assign rd_data = (rd_ptr == PW'(OUT_BYTES)) ? xsum : mem[rd_ptr[AW-1:0]];
`else
  assign rd_data = mem[rd_ptr[AW-1:0]];
`endif

endmodule

// File: rtl/tpu_host_driver.sv
// Host-side TPU driver: frames -> ui_in/fetch strobes, start pulse, result capture -> stream.
// Payload on ui_in one cycle after accept; s_ready low from START to end of DRAIN. Option macro: TPU_DRV_OUTSUM_EN.
module tpu_host_driver
  import tpu_drv_pkg::*;
#(
  parameter int RUN_CYCLES = 16,
  parameter int OUT_BYTES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  tpu_host_driver_if.master bus
);

  localparam logic [7:0] WAIT_LOAD = (RUN_CYCLES > 1) ? 8'(RUN_CYCLES - 2) : 8'd0;

  drv_state_t state, state_nx;
  logic [7:0] op_q;
  logic [7:0] len_q;
  logic [7:0] wait_q;
  logic [7:0] ui_q;
  logic       fw_q, fi_q, fs_q, err_q;
  logic       s_ready_c, s_acc;
  logic       m_valid_c;
  logic       wr_done, rd_last;
  logic [7:0] rd_data;

  assign s_ready_c = (state == S_IDLE) || (state == S_LEN) || (state == S_LOAD);
  assign s_acc     = bus.s_valid && s_ready_c;
  assign m_valid_c = (state == S_DRAIN);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (s_acc) begin
          if (is_load_op(bus.s_data))     state_nx = S_LEN;
          else if (bus.s_data == OP_RUN)  state_nx = S_START;
        end
      end
      S_LEN:     if (s_acc) state_nx = (bus.s_data == 8'd0) ? S_IDLE : S_LOAD;
      S_LOAD:    if (s_acc && len_q == 8'd1) state_nx = S_IDLE;
      S_START:   state_nx = (RUN_CYCLES > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_q == 8'd0) state_nx = S_CAPTURE;
      S_CAPTURE: if (wr_done) state_nx = S_DRAIN;
      S_DRAIN:   if (bus.m_ready && rd_last) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_q   <= 8'h00;
      len_q  <= 8'h00;
      wait_q <= 8'h00;
      ui_q   <= 8'h00;
      fw_q   <= 1'b0;
      fi_q   <= 1'b0;
      fs_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      fw_q  <= 1'b0;
      fi_q  <= 1'b0;
      fs_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: if (s_acc) begin
          op_q  <= bus.s_data;
          err_q <= !is_load_op(bus.s_data) && (bus.s_data != OP_RUN);
        end
        S_LEN:  if (s_acc) len_q <= bus.s_data;
        // ui_in holds the last payload byte between accepts.
        S_LOAD: if (s_acc) begin
          ui_q  <= bus.s_data;
          fw_q  <= (op_q == OP_W);
          fi_q  <= (op_q == OP_INP);
          fs_q  <= (op_q == OP_INS);
          len_q <= len_q - 8'd1;
        end
        S_START: wait_q <= WAIT_LOAD;
        S_WAIT:  if (wait_q != 8'd0) wait_q <= wait_q - 8'd1;
        default: ;
      endcase
    end
  end

  drv_result_buf #(.OUT_BYTES(OUT_BYTES)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == S_START),
    .wr_en   (state == S_CAPTURE),
    .wr_data (bus.tpu_out),
    .wr_done (wr_done),
    .rd_adv  (m_valid_c && bus.m_ready),
    .rd_data (rd_data),
    .rd_last (rd_last)
  );

  assign bus.s_ready   = s_ready_c;
  assign bus.ui_in     = ui_q;
  assign bus.fetch_w   = fw_q;
  assign bus.fetch_inp = fi_q;
  assign bus.fetch_ins = fs_q;
  assign bus.start     = (state == S_START);
  assign bus.m_valid   = m_valid_c;
  assign bus.m_data    = m_valid_c ? rd_data : 8'h00;
  assign bus.m_last    = m_valid_c && rd_last;
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;

endmodule
